// File: rtl/hatch_ctrl.sv
// rtl/hatch_ctrl.sv - egg incubation/hatching sequencer driving the dot-matrix display
module hatch_ctrl #(
    parameter int TICK_DIV  = 1000,
    parameter int STAGE_SEC = 3,
    parameter int CRACK_SEC = 2,
    parameter int BAD_LIMIT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_stop,
    input  logic       temp_ok,
    output logic       st,
    output logic       temp,
    output logic [3:0] num,
    output logic       hatched
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0] STAGE_LAST = 8'(STAGE_SEC - 1);
    localparam logic [7:0] CRACK_LAST = 8'(CRACK_SEC - 1);
    localparam logic [7:0] BAD_LAST   = 8'(BAD_LIMIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INCUB = 3'd1;
    localparam logic [2:0] S_HATCH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    logic start_s1_q, start_s2_q, start_s3_q;
    logic stop_s1_q, stop_s2_q, stop_s3_q;
    logic temp_s1_q, temp_s2_q;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    bad_q, bad_d;
    logic [3:0]    num_q, num_d;
    logic          st_q, st_d;
    logic          temp_q, temp_d;
    logic          hatched_q, hatched_d;

    logic       start_ev;
    logic       stop_ev;
    logic       tick;
    logic [7:0] sec_last;

    assign start_ev = start_s2_q & ~start_s3_q;
    assign stop_ev  = stop_s2_q & ~stop_s3_q;
    assign tick     = (presc_q == PRESC_LAST);
    assign sec_last = (state_q == S_HATCH) ? CRACK_LAST : STAGE_LAST;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        bad_d   = bad_q;
        num_d   = num_q;
        if (stop_ev) begin
            state_d = S_IDLE;
            presc_d = '0;
            sec_d   = 8'd0;
            bad_d   = 8'd0;
            num_d   = 4'd0;
        end else begin
            case (state_q)
                S_INCUB, S_HATCH: begin
                    // tick wraps the prescaler, so leaving for DONE/FAIL also leaves it at 0
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (temp_s2_q) begin
                            bad_d = 8'd0;
                            if (sec_q == sec_last) begin
                                sec_d = 8'd0;
                                if (state_q == S_INCUB && num_q == 4'd5) begin
                                    state_d = S_HATCH;
                                    num_d   = 4'd6;
                                end else if (state_q == S_HATCH && num_q == 4'd7) begin
                                    state_d = S_DONE;
                                    num_d   = 4'd8;
                                end else begin
                                    num_d = num_q + 4'd1;
                                end
                            end else begin
                                sec_d = sec_q + 8'd1;
                            end
                        end else if (bad_q == BAD_LAST) begin
                            state_d = S_FAIL;
                            num_d   = 4'd9;
                            sec_d   = 8'd0;
                            bad_d   = 8'd0;
                        end else begin
                            bad_d = bad_q + 8'd1;
                        end
                    end
                end
                default: begin
                    presc_d = '0;
                    if (start_ev) begin
                        state_d = S_INCUB;
                        sec_d   = 8'd0;
                        bad_d   = 8'd0;
                        num_d   = 4'd0;
                    end
                end
            endcase
        end
    end

    assign st_d      = (state_d != S_IDLE);
    assign temp_d    = st_d & ~temp_s2_q;
    assign hatched_d = (state_d == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_s3_q <= 1'b0;
            stop_s1_q  <= 1'b0;
            stop_s2_q  <= 1'b0;
            stop_s3_q  <= 1'b0;
            temp_s1_q  <= 1'b0;
            temp_s2_q  <= 1'b0;
            state_q    <= S_IDLE;
            presc_q    <= '0;
            sec_q      <= 8'd0;
            bad_q      <= 8'd0;
            num_q      <= 4'd0;
            st_q       <= 1'b0;
            temp_q     <= 1'b0;
            hatched_q  <= 1'b0;
        end else begin
            start_s1_q <= key_start;
            start_s2_q <= start_s1_q;
            start_s3_q <= start_s2_q;
            stop_s1_q  <= key_stop;
            stop_s2_q  <= stop_s1_q;
            stop_s3_q  <= stop_s2_q;
            temp_s1_q  <= temp_ok;
            temp_s2_q  <= temp_s1_q;
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            bad_q      <= bad_d;
            num_q      <= num_d;
            st_q       <= st_d;
            temp_q     <= temp_d;
            hatched_q  <= hatched_d;
        end
    end

    assign st      = st_q;
    assign temp    = temp_q;
    assign num     = num_q;
    assign hatched = hatched_q;

endmodule

// File: tb/tb_hatch_ctrl.sv
// tb/tb_hatch_ctrl.sv - scoreboard bench for hatch_ctrl with a 4-cycle second
module tb_hatch_ctrl;

    logic       clk;
    logic       rst;
    logic       key_start;
    logic       key_stop;
    logic       temp_ok;
    logic       st;
    logic       temp;
    logic [3:0] num;
    logic       hatched;

    hatch_ctrl #(
        .TICK_DIV (4),
        .STAGE_SEC(2),
        .CRACK_SEC(1),
        .BAD_LIMIT(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_start(key_start),
        .key_stop (key_stop),
        .temp_ok  (temp_ok),
        .st       (st),
        .temp     (temp),
        .num      (num),
        .hatched  (hatched)
    );

    typedef struct {
        int         cyc;
        logic       st;
        logic       tp;
        logic [3:0] num;
        logic       h;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   t_run  = 0;
    logic done   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectations are keyed by posedge count and compared mid-cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || {st, temp, num, hatched} !== {e.st, e.tp, e.num, e.h}) begin
                errors++;
                $display("FAIL %s due cyc %0d at cyc %0d: got st=%b temp=%b num=%0d hatched=%b, expected st=%b temp=%b num=%0d hatched=%b",
                         e.name, e.cyc, cyc, st, temp, num, hatched, e.st, e.tp, e.num, e.h);
            end
        end
        if (done) begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s due cyc %0d never compared", e.name, e.cyc);
            end
        end
    end

    task automatic push(input int c, input logic s, input logic t, input logic [3:0] n,
                        input logic h, input string nm);
        exp_t x;
        int   i;
        x.cyc = c; x.st = s; x.tp = t; x.num = n; x.h = h; x.name = nm;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, x);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset;
        push(2, 0, 0, 4'd0, 0, "reset_state");
        wait_cyc(3);
        rst = 1'b0;
        t_run = cyc + 3;
        key_start = 1'b1;
        push(t_run, 1, 0, 4'd0, 0, "reset_run_entry");
        push(t_run + 25, 1, 0, 4'd3, 0, "reset_pre_num3");
        wait_cyc(t_run);
        key_start = 1'b0;
        wait_cyc(t_run + 26);
        rst = 1'b1;
        push(t_run + 26, 0, 0, 4'd0, 0, "reset_async");
        push(t_run + 28, 0, 0, 4'd0, 0, "reset_held");
        wait_cyc(t_run + 29);
        rst = 1'b0;
        push(t_run + 30, 0, 0, 4'd0, 0, "reset_release");
        push(t_run + 40, 0, 0, 4'd0, 0, "reset_idle_stays");
        wait_cyc(t_run + 41);
    endtask

    task automatic test_normal_run;
        t_run = cyc + 3;
        key_start = 1'b1;
        push(t_run - 1, 0, 0, 4'd0, 0, "start_latency_pre");
        push(t_run, 1, 0, 4'd0, 0, "start_latency");
        for (int k = 1; k <= 5; k++) begin
            push(t_run + 8 * k - 1, 1, 0, 4'(k - 1), 0, "incub_hold");
            push(t_run + 8 * k, 1, 0, 4'(k), 0, "incub_step");
        end
        push(t_run + 47, 1, 0, 4'd5, 0, "incub_last_hold");
        push(t_run + 48, 1, 0, 4'd6, 0, "hatch_enter");
        push(t_run + 51, 1, 0, 4'd6, 0, "hatch6_hold");
        push(t_run + 52, 1, 0, 4'd7, 0, "hatch7");
        push(t_run + 55, 1, 0, 4'd7, 0, "hatch7_hold");
        push(t_run + 56, 1, 0, 4'd8, 1, "done_enter");
        push(t_run + 90, 1, 0, 4'd8, 1, "done_held");
        wait_cyc(t_run);
        key_start = 1'b0;
        wait_cyc(t_run + 91);
    endtask

    task automatic test_restart_and_ignore;
        t_run = cyc + 3;
        key_start = 1'b1;
        push(t_run - 1, 1, 0, 4'd8, 1, "restart_pre_done");
        push(t_run, 1, 0, 4'd0, 0, "restart_entry");
        push(t_run + 7, 1, 0, 4'd0, 0, "ignore_start_hold");
        push(t_run + 8, 1, 0, 4'd1, 0, "ignore_start_step");
        push(t_run + 15, 1, 0, 4'd1, 0, "ignore_start_hold2");
        push(t_run + 16, 1, 0, 4'd2, 0, "ignore_start_step2");
        wait_cyc(t_run);
        key_start = 1'b0;
        wait_cyc(t_run + 4);
        key_start = 1'b1;
        wait_cyc(t_run + 8);
        key_start = 1'b0;
        wait_cyc(t_run + 17);
    endtask

    task automatic test_temp_stall;
        temp_ok = 1'b0;
        push(t_run + 19, 1, 0, 4'd2, 0, "stall_pre_alarm");
        push(t_run + 20, 1, 1, 4'd2, 0, "stall_alarm");
        push(t_run + 27, 1, 1, 4'd2, 0, "stall_num_held");
        push(t_run + 28, 1, 0, 4'd2, 0, "stall_alarm_clear");
        push(t_run + 31, 1, 0, 4'd2, 0, "stall_recover_hold");
        push(t_run + 32, 1, 0, 4'd3, 0, "stall_recover_step");
        wait_cyc(t_run + 25);
        temp_ok = 1'b1;
        wait_cyc(t_run + 33);
    endtask

    task automatic test_failure;
        temp_ok = 1'b0;
        push(t_run + 36, 1, 1, 4'd3, 0, "fail_alarm");
        push(t_run + 43, 1, 1, 4'd3, 0, "fail_pre");
        push(t_run + 44, 1, 1, 4'd9, 0, "fail_enter");
        push(t_run + 60, 1, 1, 4'd9, 0, "fail_held");
        push(t_run + 63, 1, 1, 4'd9, 0, "fail_temp_live_pre");
        push(t_run + 64, 1, 0, 4'd9, 0, "fail_temp_live");
        wait_cyc(t_run + 61);
        temp_ok = 1'b1;
        wait_cyc(t_run + 65);
    endtask

    task automatic test_stop_start_clash;
        t_run = cyc + 3;
        key_start = 1'b1;
        push(t_run - 1, 1, 0, 4'd9, 0, "fail_restart_pre");
        push(t_run, 1, 0, 4'd0, 0, "fail_restart_entry");
        push(t_run + 48, 1, 0, 4'd6, 0, "clash_in_hatch");
        push(t_run + 51, 1, 0, 4'd6, 0, "clash_pre");
        push(t_run + 52, 0, 0, 4'd0, 0, "clash_stop_wins");
        push(t_run + 70, 0, 0, 4'd0, 0, "clash_idle_held");
        wait_cyc(t_run);
        key_start = 1'b0;
        wait_cyc(t_run + 49);
        key_start = 1'b1;
        key_stop  = 1'b1;
        wait_cyc(t_run + 53);
        key_start = 1'b0;
        key_stop  = 1'b0;
        wait_cyc(t_run + 71);
    endtask

    initial begin
        rst       = 1'b1;
        key_start = 1'b0;
        key_stop  = 1'b0;
        temp_ok   = 1'b1;
        test_reset;
        test_normal_run;
        test_restart_and_ignore;
        test_temp_stall;
        test_failure;
        test_stop_start_clash;
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
